// File: rtl/pran_alu_pkg.sv
// Shared ALUControl encoding and FSM state type for the PRAN execute stage.
// The ALU decoder and the serial ALU both import these constants.
package pran_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRA) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/response handshake bundle between register read, the serial ALU and writeback.
interface alu_serial_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: working register, down-counter and latched shift kind.
// The first bit is shifted on the load edge, so a shift by N needs N-1 steps.
module alu_serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               dir,
  input  logic               arith,
  input  logic [WIDTH-1:0]   load_value,
  input  logic [SHAMT_W-1:0] load_count,
  output logic [WIDTH-1:0]   first,
  output logic [WIDTH-1:0]   value,
  output logic [WIDTH-1:0]   next_value,
  output logic               last
);

  logic [WIDTH-1:0]   value_reg;
  logic [SHAMT_W-1:0] count_reg;
  logic               dir_reg;
  logic               arith_reg;

  // dir = 1 shifts right; arith selects MSB replication for right shifts.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic d, input logic a);
    if (d)
      return {a & v[WIDTH-1], v[WIDTH-1:1]};
    else
      return {v[WIDTH-2:0], 1'b0};
  endfunction

  assign first      = shift_one(load_value, dir, arith);
  assign next_value = shift_one(value_reg, dir_reg, arith_reg);
  assign value      = value_reg;
  assign last       = (count_reg == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b0;
      arith_reg <= 1'b0;
    end else if (load) begin
      value_reg <= first;
      count_reg <= load_count;
      dir_reg   <= dir;
      arith_reg <= arith;
    end else if (step) begin
      value_reg <= next_value;
      count_reg <= count_reg - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arithmetic, serial shifts,
// valid/ready on both sides and a result register held until taken.
module alu_serial
  import pran_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic         clk,
  input logic         reset,
  alu_serial_if.slave bus
);

  alu_state_t       state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             illegal_reg, illegal_next;

  logic [WIDTH-1:0]   op_result;
  logic               op_illegal;
  logic [SHAMT_W-1:0] shamt;
  logic               op_shift;
  logic               sh_load, sh_step, sh_last;
  logic [WIDTH-1:0]   sh_first, sh_value, sh_next_value;

  assign shamt    = bus.src_b[SHAMT_W-1:0];
  assign op_shift = is_shift_op(bus.alu_control);

  alu_serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .step       (sh_step),
    .dir        (bus.alu_control != ALU_SLL),
    .arith      (bus.alu_control == ALU_SRA),
    .load_value (bus.src_a),
    .load_count (shamt - SHAMT_W'(1)),
    .first      (sh_first),
    .value      (sh_value),
    .next_value (sh_next_value),
    .last       (sh_last)
  );

  // Single-cycle datapath; shifts by 0 or 1 also resolve here.
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (bus.alu_control)
      ALU_ADD:  op_result = bus.src_a + bus.src_b;
      ALU_SUB:  op_result = bus.src_a - bus.src_b;
      ALU_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      ALU_SLTU: op_result = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
      ALU_XOR:  op_result = bus.src_a ^ bus.src_b;
      ALU_OR:   op_result = bus.src_a | bus.src_b;
      ALU_AND:  op_result = bus.src_a & bus.src_b;
      ALU_SLL, ALU_SRA, ALU_SRL:
                op_result = (shamt == '0) ? bus.src_a : sh_first;
      default:  op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    sh_load      = 1'b0;
    sh_step      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          if (op_shift && (shamt > SHAMT_W'(1))) begin
            sh_load    = 1'b1;
            state_next = SHIFT;
          end else begin
            result_next  = op_result;
            zero_next    = (op_result == '0);
            illegal_next = op_illegal;
            state_next   = DONE;
          end
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_next  = sh_next_value;
          zero_next    = (sh_next_value == '0);
          illegal_next = 1'b0;
          state_next   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_serial.sv
// Randomized and directed bench for alu_serial against an arithmetic reference model.
module tb_alu_serial;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_serial_if #(.WIDTH(32)) bus ();

  alu_serial #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result and illegal flag straight from the operation definitions.
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, output logic ill);
    logic [31:0] r;
    int sh;
    sh  = int'(b & 32'h1F);
    ill = 1'b0;
    r   = '0;
    case (c)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << sh;
      4'b1101: r = a >> sh;
      4'b0101: r = $unsigned($signed(a) >>> sh);
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: ill = 1'b1;
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b & 32'h1F);
    if ((c == 4'b0001 || c == 4'b0101 || c == 4'b1101) && sh > 0)
      return sh;
    return 1;
  endfunction

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    er = model(c, a, b, ei);
    el = model_latency(c, b);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
    end
    bus.alu_control = c;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    tick();
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'($urandom);
    bus.src_a       = $urandom;
    bus.src_b       = $urandom;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== el) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, el);
    end
    checks++;
    if (bus.result !== er) begin
      failures++;
      $display("FAIL %s result: got %h want %h", name, bus.result, er);
    end
    checks++;
    if (bus.zero !== (er == 32'd0)) begin
      failures++;
      $display("FAIL %s zero: got %b want %b", name, bus.zero, (er == 32'd0));
    end
    checks++;
    if (bus.illegal !== ei) begin
      failures++;
      $display("FAIL %s illegal: got %b want %b", name, bus.illegal, ei);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name,
               bus.out_valid, bus.in_ready);
    end
    $display("op %-10s code=%b a=%h b=%h -> result=%h zero=%b illegal=%b lat=%0d",
             name, c, a, b, bus.result, bus.zero, bus.illegal, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'd0 ||
        bus.zero !== 1'b1 || bus.illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%h z=%b ill=%b want 0/1/0/1/0",
               bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.illegal);
    end
    reset = 1'b0;
    tick();
    $display("reset: out_valid=%b in_ready=%b result=%h", bus.out_valid, bus.in_ready, bus.result);
  endtask

  task automatic test_arith();
    do_op(4'b0000, 32'h7FFFFFFF, 32'h00000001, "add_wrap");
    do_op(4'b1000, 32'd5, 32'd5, "sub_zero");
    do_op(4'b1000, 32'd0, 32'd1, "sub_under");
    do_op(4'b0010, 32'hFFFFFFFF, 32'd1, "slt");
    do_op(4'b0011, 32'hFFFFFFFF, 32'd1, "sltu");
  endtask

  task automatic test_shift();
    do_op(4'b0101, 32'h80000000, 32'h00000024, "sra4");
    do_op(4'b1101, 32'h80000000, 32'h00000024, "srl4");
    do_op(4'b0001, 32'h00000001, 32'd31, "sll31");
    do_op(4'b0001, 32'h00001234, 32'h00000020, "sll0");
    do_op(4'b1101, 32'hF0000001, 32'hFFFFFFE1, "srl1");
  endtask

  task automatic test_illegal();
    do_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, "illegal");
    do_op(4'b0000, 32'd0, 32'd0, "add_clr");
  endtask

  task automatic test_backpressure();
    logic [31:0] er;
    logic        ei;
    er = model(4'b0100, 32'hA5A5A5A5, 32'h0F0F0F0F, ei);
    bus.alu_control = 4'b0100;
    bus.src_a       = 32'hA5A5A5A5;
    bus.src_b       = 32'h0F0F0F0F;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    tick();
    bus.alu_control = 4'b0000;
    bus.src_a       = 32'd1;
    bus.src_b       = 32'd2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== er) begin
        failures++;
        $display("FAIL backpressure_hold%0d: got ov=%b ir=%b res=%h want 1/0/%h",
                 i, bus.out_valid, bus.in_ready, bus.result, er);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== er) begin
      failures++;
      $display("FAIL backpressure_release: got ir=%b ov=%b res=%h want 1/0/%h",
               bus.in_ready, bus.out_valid, bus.result, er);
    end
    $display("backpressure: held result=%h then released in_ready=%b", bus.result, bus.in_ready);
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    bus.alu_control = 4'b0001;
    bus.src_a       = 32'h00000003;
    bus.src_b       = 32'd8;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'd0) begin
      failures++;
      $display("FAIL reset_abort_state: got ov=%b ir=%b res=%h want 0/1/0",
               bus.out_valid, bus.in_ready, bus.result);
    end
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_abort_emit: got %0d valid cycles want 0", seen);
    end
    $display("reset_abort: valid cycles after abort=%0d", seen);
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 60; n++) begin
      c = 4'($urandom);
      a = $urandom;
      b = $urandom;
      if (n % 3 == 0) a = a & 32'h8000_00FF;
      do_op(c, a, b, "random");
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.alu_control = 4'b0000;
    bus.src_a       = '0;
    bus.src_b       = '0;
    test_reset();
    test_arith();
    test_shift();
    test_illegal();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
